// File: rtl/ioblock_cfg_ctrl.sv
// Configuration controller for the IO block array: decodes a framed byte stream into
// per-IOB shadow settings and copies them to the live TSMUX/DORREG buses on an apply byte.
module ioblock_cfg_ctrl #(
    parameter int unsigned NUM_IOB = 41,
    parameter int unsigned ADDR_W  = 6
) (
    input  logic                   IOCLK,
    input  logic                   RST,
    input  logic [7:0]             CFG_DATA,
    input  logic                   CFG_VALID,
    output logic                   CFG_READY,
    input  logic                   ERR_CLR,
    output logic [2*NUM_IOB-1:0]   TSMUX_BUS,
    output logic [NUM_IOB-1:0]     DORREG_BUS,
    output logic                   ERR_CHK,
    output logic                   ERR_ADDR,
    output logic [7:0]             FRAME_CNT,
    output logic                   BUSY
);

    localparam logic [7:0] SyncByte  = 8'hA5;
    localparam logic [7:0] ApplyByte = 8'h5A;
    localparam logic [7:0] NumIobB   = 8'(NUM_IOB);

    typedef enum logic [2:0] {
        StSync,
        StAddr,
        StData,
        StChk,
        StApply
    } state_e;

    state_e               state;
    logic [7:0]           addr_byte;
    logic [7:0]           cfg_byte;
    logic [2*NUM_IOB-1:0] shadow_ts;
    logic [NUM_IOB-1:0]   shadow_dor;

    logic xfer;
    logic chk_ok;
    logic addr_ok;

    always_comb begin
        xfer    = CFG_VALID & CFG_READY;
        chk_ok  = (CFG_DATA == (addr_byte ^ cfg_byte));
        addr_ok = (addr_byte < NumIobB);
    end

    always_ff @(posedge IOCLK) begin
        if (RST) begin
            state      <= StSync;
            addr_byte  <= 8'h00;
            cfg_byte   <= 8'h00;
            shadow_ts  <= '0;
            shadow_dor <= '0;
            TSMUX_BUS  <= '0;
            DORREG_BUS <= '0;
            ERR_CHK    <= 1'b0;
            ERR_ADDR   <= 1'b0;
            FRAME_CNT  <= 8'h00;
            CFG_READY  <= 1'b1;
            BUSY       <= 1'b0;
        end else begin
            // Clear first so an error raised on the same edge overrides it.
            if (ERR_CLR) begin
                ERR_CHK  <= 1'b0;
                ERR_ADDR <= 1'b0;
            end

            unique case (state)
                StSync: begin
                    if (xfer) begin
                        if (CFG_DATA == SyncByte) begin
                            state <= StAddr;
                            BUSY  <= 1'b1;
                        end else if (CFG_DATA == ApplyByte) begin
                            state     <= StApply;
                            BUSY      <= 1'b1;
                            CFG_READY <= 1'b0;
                        end
                    end
                end

                StAddr: begin
                    if (xfer) begin
                        addr_byte <= CFG_DATA;
                        state     <= StData;
                    end
                end

                StData: begin
                    if (xfer) begin
                        cfg_byte <= CFG_DATA;
                        state    <= StChk;
                    end
                end

                StChk: begin
                    if (xfer) begin
                        state <= StSync;
                        BUSY  <= 1'b0;
                        if (!chk_ok) begin
                            ERR_CHK <= 1'b1;
                        end else if (!addr_ok) begin
                            ERR_ADDR <= 1'b1;
                        end else begin
                            for (int i = 0; i < NUM_IOB; i++) begin
                                if (addr_byte[ADDR_W-1:0] == ADDR_W'(i)) begin
                                    shadow_ts[2*i +: 2] <= cfg_byte[1:0];
                                    shadow_dor[i]       <= cfg_byte[2];
                                end
                            end
                            FRAME_CNT <= FRAME_CNT + 8'h01;
                        end
                    end
                end

                StApply: begin
                    TSMUX_BUS  <= shadow_ts;
                    DORREG_BUS <= shadow_dor;
                    state      <= StSync;
                    CFG_READY  <= 1'b1;
                    BUSY       <= 1'b0;
                end

                default: begin
                    state     <= StSync;
                    CFG_READY <= 1'b1;
                    BUSY      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ioblock_cfg_ctrl.sv
// Scoreboard bench for ioblock_cfg_ctrl: a byte-stream reference model queues the expected
// visible state per cycle and a negedge monitor compares it against the DUT outputs.
module tb_ioblock_cfg_ctrl;

    localparam int N = 41;

    logic             IOCLK = 1'b0;
    logic             RST = 1'b1;
    logic [7:0]       CFG_DATA = 8'h00;
    logic             CFG_VALID = 1'b0;
    logic             CFG_READY;
    logic             ERR_CLR = 1'b0;
    logic [2*N-1:0]   TSMUX_BUS;
    logic [N-1:0]     DORREG_BUS;
    logic             ERR_CHK;
    logic             ERR_ADDR;
    logic [7:0]       FRAME_CNT;
    logic             BUSY;

    ioblock_cfg_ctrl #(.NUM_IOB(N), .ADDR_W(6)) dut (
        .IOCLK     (IOCLK),
        .RST       (RST),
        .CFG_DATA  (CFG_DATA),
        .CFG_VALID (CFG_VALID),
        .CFG_READY (CFG_READY),
        .ERR_CLR   (ERR_CLR),
        .TSMUX_BUS (TSMUX_BUS),
        .DORREG_BUS(DORREG_BUS),
        .ERR_CHK   (ERR_CHK),
        .ERR_ADDR  (ERR_ADDR),
        .FRAME_CNT (FRAME_CNT),
        .BUSY      (BUSY)
    );

    always #5 IOCLK = ~IOCLK;

    int cyc = 0;
    always @(posedge IOCLK) cyc <= cyc + 1;

    typedef struct {
        int             due;
        logic [2*N-1:0] ts;
        logic [N-1:0]   dor;
        logic           chk;
        logic           adr;
        logic [7:0]     fcnt;
        logic           rdy;
        logic           busy;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    // Reference model: frame position, pending apply, shadow/live tables, flags, count.
    int         m_pos;
    bit         m_apply;
    logic [1:0] m_sts[N];
    logic       m_sdor[N];
    logic [1:0] m_lts[N];
    logic       m_ldor[N];
    bit         m_errc, m_erra;
    int         m_fcnt;
    logic [7:0] m_addr, m_cfg;

    task automatic model_edge(input bit rst, input bit v, input bit clr, input logic [7:0] d);
        if (rst) begin
            m_pos = 0; m_apply = 0; m_errc = 0; m_erra = 0; m_fcnt = 0;
            for (int i = 0; i < N; i++) begin
                m_sts[i] = 2'b00; m_sdor[i] = 1'b0; m_lts[i] = 2'b00; m_ldor[i] = 1'b0;
            end
            return;
        end
        if (clr) begin
            m_errc = 0;
            m_erra = 0;
        end
        if (m_apply) begin
            for (int i = 0; i < N; i++) begin
                m_lts[i]  = m_sts[i];
                m_ldor[i] = m_sdor[i];
            end
            m_apply = 0;
        end else if (v) begin
            case (m_pos)
                0: if (d == 8'hA5) m_pos = 1; else if (d == 8'h5A) m_apply = 1;
                1: begin m_addr = d; m_pos = 2; end
                2: begin m_cfg = d; m_pos = 3; end
                default: begin
                    m_pos = 0;
                    if (d != (m_addr ^ m_cfg)) m_errc = 1;
                    else if (int'(m_addr) >= N) m_erra = 1;
                    else begin
                        m_sts[m_addr]  = m_cfg[1:0];
                        m_sdor[m_addr] = m_cfg[2];
                        m_fcnt = (m_fcnt + 1) % 256;
                    end
                end
            endcase
        end
    endtask

    task automatic push_exp(input int due);
        exp_t e;
        e.due = due;
        for (int i = 0; i < N; i++) begin
            e.ts[2*i +: 2] = m_lts[i];
            e.dor[i] = m_ldor[i];
        end
        e.chk  = m_errc;
        e.adr  = m_erra;
        e.fcnt = 8'(m_fcnt);
        e.rdy  = !m_apply;
        e.busy = (m_pos != 0) || m_apply;
        exp_q.push_back(e);
    endtask

    // One clock: drive inputs, predict the state after the coming edge.
    task automatic step(input bit r, input bit v, input logic [7:0] d, input bit c);
        RST = r; CFG_VALID = v; CFG_DATA = d; ERR_CLR = c;
        model_edge(r, v, c, d);
        push_exp(cyc + 1);
        @(negedge IOCLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
    endtask

    // Holds the byte valid until the model predicts it is accepted.
    task automatic send(input logic [7:0] b, input bit clr = 0);
        bit done;
        done = 0;
        while (!done) begin
            done = !m_apply;
            step(0, 1, b, clr);
        end
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] k,
                         input bit gaps, input bit clr_last);
        send(8'hA5);
        if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send(a);
        if (gaps && $urandom_range(0, 3) == 0) idle(1);
        send(c);
        if (gaps && $urandom_range(0, 3) == 0) idle(1);
        send(k, clr_last);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Monitor: every negedge, compare DUT outputs with the entry due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge IOCLK);
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                chk("missed_entry", 128'(e.due), 128'(cyc));
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("tsmux_bus",  128'(TSMUX_BUS),  128'(e.ts));
                chk("dorreg_bus", 128'(DORREG_BUS), 128'(e.dor));
                chk("err_chk",    128'(ERR_CHK),    128'(e.chk));
                chk("err_addr",   128'(ERR_ADDR),   128'(e.adr));
                chk("frame_cnt",  128'(FRAME_CNT),  128'(e.fcnt));
                chk("cfg_ready",  128'(CFG_READY),  128'(e.rdy));
                chk("busy",       128'(BUSY),       128'(e.busy));
            end
        end
    end

    initial begin
        logic [7:0] a, c, k, nb;
        @(negedge IOCLK);
        #1;
        do_reset();
        idle(2);

        // Good write, buses stay put until apply.
        frame(8'h03, 8'h06, 8'h05, 0, 0);
        idle(3);
        send(8'h5A);
        idle(3);

        // Bad checksum, then clear.
        frame(8'h03, 8'h06, 8'h04, 0, 0);
        idle(2);
        step(0, 0, 8'h00, 1);
        idle(1);

        // Address out of range, then highest valid address.
        frame(8'h29, 8'h01, 8'h28, 0, 0);
        frame(8'h28, 8'h01, 8'h29, 0, 0);
        send(8'h5A);
        idle(2);

        // Back-to-back applies with valid held, then an immediate frame.
        send(8'h5A);
        send(8'h5A);
        frame(8'h10, 8'h07, 8'h17, 0, 0);
        send(8'h5A);
        idle(2);

        // Error raised on the same edge as a clear: set wins.
        frame(8'h05, 8'h02, 8'h00, 0, 1);
        idle(1);
        step(0, 0, 8'h00, 1);

        // Reset mid-frame, trailing bytes become noise.
        frame(8'h07, 8'h03, 8'h04, 0, 0);
        send(8'h5A);
        send(8'hA5);
        send(8'h03);
        do_reset();
        send(8'h06);
        send(8'h05);
        idle(2);

        // Randomized traffic.
        for (int t = 0; t < 600; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    a = 8'($urandom_range(0, 50));
                    c = 8'($urandom);
                    k = a ^ c;
                    if ($urandom_range(0, 9) == 0) k = k ^ 8'($urandom_range(1, 255));
                    frame(a, c, k, 1, $urandom_range(0, 9) == 0);
                end
                4, 5: send(8'h5A);
                6: begin
                    nb = 8'($urandom);
                    if (nb == 8'hA5 || nb == 8'h5A) nb = 8'h00;
                    send(nb);
                end
                7: idle($urandom_range(1, 3));
                8: step(0, $urandom_range(0, 1) == 1 && !m_apply && m_pos == 0, 8'h11, 1);
                default: if ($urandom_range(0, 15) == 0) do_reset(); else idle(1);
            endcase
        end

        // Counter wrap.
        do_reset();
        for (int t = 0; t < 256; t++) begin
            a = 8'($urandom_range(0, N - 1));
            c = 8'($urandom);
            frame(a, c, a ^ c, 0, 0);
        end
        send(8'h5A);
        idle(4);

        repeat (3) @(negedge IOCLK);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
